// File: rtl/lfsr_keystream_ctrl_if.sv
// lfsr_keystream_ctrl_if: valid/ready keystream word channel
interface lfsr_keystream_ctrl_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    modport master (output o_data, o_valid, input i_ready);
    modport slave (input o_data, o_valid, output i_ready);
endinterface

// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl: seeds and warms up a 64-bit LFSR, then packs its bits into handshaked words
module lfsr_keystream_ctrl #(
    parameter int          WARMUP_CYCLES = 128,
    parameter int          OUT_W         = 8,
    parameter logic [63:0] DEFAULT_SEED  = 64'hACE1_5EED_0BAD_F00D
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [63:0]                  i_seed,
    input  logic [15:0]                  i_len,
    input  logic                         i_stop,
    input  logic                         i_ks_bit,
    output logic                         o_lfsr_load,
    output logic [63:0]                  o_lfsr_seed,
    output logic                         o_lfsr_en,
    lfsr_keystream_ctrl_if.master        ks,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_seed_err,
    output logic [31:0]                  o_word_cnt
);
    localparam int BW = $clog2(OUT_W + 1);
    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_e;
    state_e           state_q, state_d;
    logic [63:0]      seed_q, seed_d;
    logic [15:0]      len_q, len_d, prod_q, prod_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0] sr_q, sr_d, data_q, data_d;
    logic             valid_q, valid_d, seed_err_q, seed_err_d;
    logic [31:0]      word_cnt_q, word_cnt_d, warm_cnt_q, warm_cnt_d;
    logic             hs, start, xfer;
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        len_d       = len_q;
        prod_d      = prod_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        data_d      = data_q;
        warm_cnt_d  = warm_cnt_q;
        seed_err_d  = 1'b0;
        hs          = valid_q && ks.i_ready;
        start       = 1'b0;
        xfer        = 1'b0;
        o_done      = 1'b0;
        o_lfsr_en   = 1'b0;
        o_lfsr_load = state_q == LOAD;
        case (state_q)
            IDLE: if (i_start) begin
                start      = 1'b1;
                state_d    = LOAD;
                seed_d     = (i_seed == 64'd0) ? DEFAULT_SEED : i_seed;
                seed_err_d = i_seed == 64'd0;
                len_d      = i_len;
                prod_d     = 16'd0;
                bit_cnt_d  = '0;
                sr_d       = '0;
            end
            LOAD: begin
                state_d    = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
                warm_cnt_d = 32'd0;
            end
            WARMUP: begin
                o_lfsr_en  = 1'b1;
                warm_cnt_d = warm_cnt_q + 32'd1;
                state_d    = (warm_cnt_q == 32'(WARMUP_CYCLES - 1)) ? RUN : WARMUP;
            end
            RUN: begin
                o_lfsr_en = bit_cnt_q < BW'(OUT_W);
                if (o_lfsr_en) begin
                    sr_d      = {sr_q[OUT_W-2:0], i_ks_bit};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else if (!valid_q || ks.i_ready) begin
                    xfer      = 1'b1;
                    data_d    = sr_q;
                    bit_cnt_d = '0;
                    prod_d    = prod_q + 16'd1;
                    o_done    = (len_q != 16'd0) && (prod_d == len_q);
                    state_d   = o_done ? IDLE : RUN;
                end
            end
        endcase
        // abort wins over everything: partial bits go, a pending word stays
        if (i_stop && state_q != IDLE) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sr_d      = '0;
            xfer      = 1'b0;
            o_done    = 1'b0;
            data_d    = data_q;
            prod_d    = prod_q;
        end
        valid_d    = xfer || (valid_q && !ks.i_ready);
        word_cnt_d = (start ? 32'd0 : word_cnt_q) + {31'd0, hs};
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            len_q      <= '0;
            prod_q     <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            seed_err_q <= 1'b0;
            word_cnt_q <= '0;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            len_q      <= len_d;
            prod_q     <= prod_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            seed_err_q <= seed_err_d;
            word_cnt_q <= word_cnt_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end
    assign ks.o_data   = data_q;
    assign ks.o_valid  = valid_q;
    assign o_lfsr_seed = seed_q;
    assign o_busy      = state_q != IDLE;
    assign o_seed_err  = seed_err_q;
    assign o_word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
// tb_lfsr_keystream_ctrl: drives sessions against an LFSR environment and a keystream word model
module tb_lfsr_keystream_ctrl;
    localparam int          WU  = 128;
    localparam int          OW  = 8;
    localparam logic [63:0] DEF = 64'hACE1_5EED_0BAD_F00D;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [63:0] seed = 64'd0, lseed, lfsr = 64'd0;
    logic [15:0] len = 16'd0;
    logic        load, en, busy, done, serr;
    logic [31:0] wcnt;
    int          nchk = 0, nerr = 0;
    int          hs_n = 0, load_n = 0, en_n = 0, done_n = 0, serr_n = 0;
    int          cycle = 0, last_hs = 0, gap = 0, done_hs = 0;
    logic        hold = 1'b0, prev_done = 1'b0, busy_after_done = 1'b1;
    logic [OW-1:0] hold_data = '0, last_data = '0, w0, ew;
    logic [OW-1:0] exp_q[$];
    lfsr_keystream_ctrl_if #(.OUT_W(OW)) ks();
    lfsr_keystream_ctrl #(.WARMUP_CYCLES(WU), .OUT_W(OW), .DEFAULT_SEED(DEF)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed), .i_len(len), .i_stop(stop),
        .i_ks_bit(lfsr[63]), .o_lfsr_load(load), .o_lfsr_seed(lseed), .o_lfsr_en(en), .ks(ks),
        .o_busy(busy), .o_done(done), .o_seed_err(serr), .o_word_cnt(wcnt));
    always #5 clk = ~clk;
    function automatic logic [63:0] step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction
    always @(posedge clk) if (load) lfsr <= lseed; else if (en) lfsr <= step(lfsr);
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic build(input logic [63:0] sd);
        logic [63:0]   s;
        logic [OW-1:0] w;
        s = (sd == 64'd0) ? DEF : sd;
        w = '0;
        exp_q.delete();
        repeat (WU) s = step(s);
        for (int k = 0; k < 64; k++) begin
            for (int b = 0; b < OW; b++) begin
                w = {w[OW-2:0], s[63]};
                s = step(s);
            end
            exp_q.push_back(w);
        end
    endtask
    // observes the current cycle with inputs already set for the coming edge, then advances
    task automatic cyc();
        cycle++;
        if (rst) hold = 1'b0;
        else begin
            if (hold) begin
                check("hold_valid", 64'(ks.o_valid), 64'd1);
                check("hold_data", 64'(ks.o_data), 64'(hold_data));
            end
            if (done) done_hs = hs_n;
            if (prev_done) busy_after_done = busy;
            if (ks.o_valid && ks.i_ready) begin
                hs_n++;
                gap = cycle - last_hs;
                last_hs = cycle;
                last_data = ks.o_data;
                check("sb_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ew = exp_q.pop_front();
                    check("word", 64'(ks.o_data), 64'(ew));
                end
            end
            load_n += int'(load);
            en_n   += int'(en);
            done_n += int'(done);
            serr_n += int'(serr);
            hold      = ks.o_valid && !ks.i_ready;
            hold_data = ks.o_data;
            prev_done = done;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic start_session(input logic [63:0] sd, input logic [15:0] ln);
        build(sd);
        seed  = sd;
        len   = ln;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask
    task automatic wait_hs(input string tag, input int n);
        int b = hs_n;
        int g = 0;
        while (hs_n - b < n && g < 3000) begin
            cyc();
            g++;
        end
        check(tag, 64'(hs_n - b), 64'(n));
    endtask
    task automatic check_reset();
        check("rst_valid", 64'(ks.o_valid), 64'd0);
        check("rst_data", 64'(ks.o_data), 64'd0);
        check("rst_load", 64'(load), 64'd0);
        check("rst_en", 64'(en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_serr", 64'(serr), 64'd0);
        check("rst_seed", lseed, 64'd0);
        check("rst_wcnt", 64'(wcnt), 64'd0);
    endtask
    initial begin
        int bld, ben, bdn, bse, bh, n, g;
        logic [63:0] sd;
        ks.i_ready = 1'b1;
        repeat (3) cyc();
        check_reset();
        rst = 1'b0;
        cyc();
        // first session: seed 1, unlimited, always ready
        bld = load_n; ben = en_n; bdn = done_n;
        start_session(64'h1, 16'd0);
        check("a_seed", lseed, 64'h1);
        check("a_busy", 64'(busy), 64'd1);
        n = 0;
        while (!ks.o_valid && n < 400) begin
            cyc();
            n++;
        end
        check("a_latency", 64'(n), 64'(WU + 10));
        check("a_en_before_word", 64'(en_n - ben), 64'(WU + OW));
        check("a_load_cycles", 64'(load_n - bld), 64'd1);
        wait_hs("a_words", 10);
        check("a_gap", 64'(gap), 64'(OW + 1));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("a_stop_idle", 64'(busy), 64'd0);
        repeat (3) cyc();
        check("a_no_done", 64'(done_n - bdn), 64'd0);
        // zero seed, length 5, random back-pressure
        bse = serr_n; bdn = done_n; bh = hs_n;
        start_session(64'd0, 16'd5);
        check("b_seed", lseed, DEF);
        g = 0;
        while (hs_n - bh < 5 && g < 3000) begin
            ks.i_ready = 1'($urandom_range(0, 1));
            cyc();
            g++;
        end
        ks.i_ready = 1'b1;
        check("b_words", 64'(hs_n - bh), 64'd5);
        repeat (20) cyc();
        check("b_busy", 64'(busy), 64'd0);
        check("b_seed_err", 64'(serr_n - bse), 64'd1);
        check("b_done", 64'(done_n - bdn), 64'd1);
        check("b_wcnt", 64'(wcnt), 64'd5);
        check("b_no_extra", 64'(hs_n - bh), 64'd5);
        // length 3 with done timing
        sd = {$urandom, $urandom} | 64'h1;
        bdn = done_n; bh = hs_n;
        start_session(sd, 16'd3);
        wait_hs("c_words", 3);
        repeat (20) cyc();
        check("c_done", 64'(done_n - bdn), 64'd1);
        check("c_done_at3", 64'(done_hs - bh), 64'd2);
        check("c_busy_after_done", 64'(busy_after_done), 64'd0);
        check("c_total", 64'(hs_n - bh), 64'd3);
        check("c_wcnt", 64'(wcnt), 64'd3);
        // consumer stall
        sd = {$urandom, $urandom} | 64'h2;
        bh = hs_n;
        start_session(sd, 16'd0);
        wait_hs("d_pre", 3);
        ks.i_ready = 1'b0;
        repeat (20) cyc();
        ben = en_n;
        repeat (20) cyc();
        check("d_stall_en", 64'(en_n - ben), 64'd0);
        check("d_valid_held", 64'(ks.o_valid), 64'd1);
        ks.i_ready = 1'b1;
        wait_hs("d_post", 6);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (3) cyc();
        check("d_wcnt", 64'(wcnt), 64'(hs_n - bh));
        // abort mid-word, then restart with the same seed
        sd = {$urandom, $urandom} | 64'h4;
        ben = en_n; bdn = done_n; bh = hs_n;
        start_session(sd, 16'd0);
        w0 = exp_q[0];
        g = 0;
        while (en_n - ben < WU + 4 && g < 1000) begin
            cyc();
            g++;
        end
        check("e_valid_before_stop", 64'(ks.o_valid), 64'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("e_stop_idle", 64'(busy), 64'd0);
        repeat (3) cyc();
        check("e_no_done", 64'(done_n - bdn), 64'd0);
        check("e_no_word", 64'(hs_n - bh), 64'd0);
        start_session(sd, 16'd0);
        wait_hs("e_restart", 1);
        check("e_restart_w0", 64'(last_data), 64'(w0));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (3) cyc();
        // reset during warm-up, start held high through reset
        start_session({$urandom, $urandom}, 16'd0);
        repeat (50) cyc();
        check("f_warmup_en", 64'(en), 64'd1);
        rst = 1'b1;
        start = 1'b1;
        cyc();
        check_reset();
        cyc();
        check_reset();
        rst = 1'b0;
        start = 1'b0;
        cyc();
        check("f_idle_after_rst", 64'(busy), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
